// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: writeback result sources and load formats.
// The decoder, MEM stage and WB stage all import these so the encodings stay in one place.
package mips_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_HILO = 2'b11;

    localparam logic [2:0] LOAD_LW  = 3'd0;
    localparam logic [2:0] LOAD_LH  = 3'd1;
    localparam logic [2:0] LOAD_LHU = 3'd2;
    localparam logic [2:0] LOAD_LB  = 3'd3;
    localparam logic [2:0] LOAD_LBU = 3'd4;

endpackage

// File: rtl/load_extractor.sv
// Little-endian sub-word load formatting (sign/zero extension of byte and halfword loads).
// Purely combinational so the MEM-stage forwarding path can reuse it.
module load_extractor
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            loadType,
    input  logic [1:0]            byteOffset,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] result
);

    logic [15:0] halfVal;
    logic [7:0]  byteVal;

    always_comb begin
        halfVal = byteOffset[1] ? data[31:16] : data[15:0];
        byteVal = data[7:0];
        case (byteOffset)
            2'd0:    byteVal = data[7:0];
            2'd1:    byteVal = data[15:8];
            2'd2:    byteVal = data[23:16];
            default: byteVal = data[31:24];
        endcase

        // Unused type codes fall through to a full-word load.
        result = data;
        case (loadType)
            LOAD_LH:  result = {{(DATA_WIDTH-16){halfVal[15]}}, halfVal};
            LOAD_LHU: result = {{(DATA_WIDTH-16){1'b0}}, halfVal};
            LOAD_LB:  result = {{(DATA_WIDTH-8){byteVal[7]}}, byteVal};
            LOAD_LBU: result = {{(DATA_WIDTH-8){1'b0}}, byteVal};
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback: selects the retiring result, owns HI/LO,
// and drives the register-file write port straight from flops.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  memValid,
    input  logic                  memRegWrite,
    input  logic [1:0]            memWbSel,
    input  logic [2:0]            memLoadType,
    input  logic [1:0]            memByteOffset,
    input  logic [DATA_WIDTH-1:0] memAluResult,
    input  logic [DATA_WIDTH-1:0] memLoadData,
    input  logic [DATA_WIDTH-1:0] memPcPlus8,
    input  logic [ADDR_WIDTH-1:0] memDestReg,
    input  logic                  memHiLoWrite,
    input  logic [DATA_WIDTH-1:0] memHiIn,
    input  logic [DATA_WIDTH-1:0] memLoIn,
    input  logic                  memHiLoSel,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  wbValid,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    logic [DATA_WIDTH-1:0] loadResult;
    logic [DATA_WIDTH-1:0] selResult;

    load_extractor #(.DATA_WIDTH(DATA_WIDTH)) u_load_extractor (
        .loadType   (memLoadType),
        .byteOffset (memByteOffset),
        .data       (memLoadData),
        .result     (loadResult)
    );

    // HI/LO moves read the current flops, so a same-instruction write is not visible yet.
    always_comb begin
        selResult = memAluResult;
        case (memWbSel)
            WB_SEL_LOAD: selResult = loadResult;
            WB_SEL_LINK: selResult = memPcPlus8;
            WB_SEL_HILO: selResult = memHiLoSel ? hi : lo;
            default:     selResult = memAluResult;
        endcase
    end

    // Flush beats stall; a non-valid capture is the same bubble as a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite     <= 1'b0;
            writeAddress <= '0;
            writeData    <= '0;
            wbValid      <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else if (flush || (!stall && !memValid)) begin
            regWrite     <= 1'b0;
            writeAddress <= '0;
            writeData    <= '0;
            wbValid      <= 1'b0;
        end else if (!stall) begin
            regWrite     <= memRegWrite && (memDestReg != '0);
            writeAddress <= memDestReg;
            writeData    <= selResult;
            wbValid      <= 1'b1;
            if (memHiLoWrite) begin
                hi <= memHiIn;
                lo <= memLoIn;
            end
        end
    end

endmodule
